// File: rtl/piso_tx_if.sv
// Parallel word in (valid/ready) and bit-serial stream out (valid/ready/last) for piso_tx.
interface piso_tx_if #(
  parameter int Width = 4
);
  logic [Width-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic             ser_o;
  logic             ser_valid_o;
  logic             ser_last_o;
  logic             ser_ready_i;

  modport slave (
    input  data_i, valid_i, ser_ready_i,
    output ready_o, ser_o, ser_valid_o, ser_last_o
  );

  modport master (
    output data_i, valid_i, ser_ready_i,
    input  ready_o, ser_o, ser_valid_o, ser_last_o
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: first bit 1 cycle after accept, then one bit per beat.
// ser_ready_i low stalls indefinitely; the next word is taken on the last-bit beat (no bubble).
module piso_tx #(
  parameter int Width    = 4,
  parameter bit MsbFirst = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  piso_tx_if.slave   bus
);
  localparam int              CntW    = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);
  localparam logic [0:0]      StIdle  = 1'b0;
  localparam logic [0:0]      StShift = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [Width-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             in_shift, last, beat, ready, accept;

  assign in_shift = (state_q == StShift);
  assign last     = in_shift && (cnt_q == CntLast);
  assign beat     = in_shift && bus.ser_ready_i;
  // Gated by rst_ni so the upstream never sees ready while reset is held.
  assign ready    = rst_ni && (!in_shift || (last && bus.ser_ready_i));
  assign accept   = bus.valid_i && ready;

  assign bus.ready_o     = ready;
  assign bus.ser_valid_o = in_shift;
  assign bus.ser_last_o  = last;
  assign bus.ser_o       = MsbFirst ? shift_q[Width-1] : shift_q[0];

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = StShift;
      shift_d = bus.data_i;
      cnt_d   = '0;
    end else if (beat) begin
      if (last) begin
        state_d = StIdle;
        shift_d = '0;
        cnt_d   = '0;
      end else begin
        shift_d = MsbFirst ? (shift_q << 1) : (shift_q >> 1);
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx at Width=4, with one LSB-first and one MSB-first instance.
module tb_piso_tx;
  logic clk;
  logic rst_n;
  bit   sel;
  int   checks;
  int   errs;

  piso_tx_if #(.Width(4)) if_l ();
  piso_tx_if #(.Width(4)) if_m ();

  piso_tx #(.Width(4), .MsbFirst(1'b0)) u_lsb (.clk_i(clk), .rst_ni(rst_n), .bus(if_l.slave));
  piso_tx #(.Width(4), .MsbFirst(1'b1)) u_msb (.clk_i(clk), .rst_ni(rst_n), .bus(if_m.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic o_vld, o_ser, o_last, o_rdy;
  assign o_vld  = sel ? if_m.ser_valid_o : if_l.ser_valid_o;
  assign o_ser  = sel ? if_m.ser_o       : if_l.ser_o;
  assign o_last = sel ? if_m.ser_last_o  : if_l.ser_last_o;
  assign o_rdy  = sel ? if_m.ready_o     : if_l.ready_o;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit msb, input logic v, input logic [3:0] d, input logic sr);
    if (msb) begin
      if_m.valid_i = v; if_m.data_i = d; if_m.ser_ready_i = sr;
    end else begin
      if_l.valid_i = v; if_l.data_i = d; if_l.ser_ready_i = sr;
    end
  endtask

  // bits_exp[i] is the i-th transmitted bit, worked out by hand per word.
  task automatic send_word(input bit msb, input logic [3:0] data, input logic [3:0] bits_exp,
                           input string tag);
    sel = msb;
    @(negedge clk);
    set_in(msb, 1'b1, data, 1'b1);
    #1 chk({tag, "_idle_rdy"}, o_rdy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("%s_vld%0d", tag, i), o_vld, 1'b1);
      chk($sformatf("%s_bit%0d", tag, i), o_ser, bits_exp[i]);
      chk($sformatf("%s_last%0d", tag, i), o_last, i == 3);
      chk($sformatf("%s_rdy%0d", tag, i), o_rdy, i == 3);
      if (i == 0) set_in(msb, 1'b0, ~data, 1'b1);
    end
    @(negedge clk);
    chk({tag, "_done_vld"}, o_vld, 1'b0);
  endtask

  logic [7:0] b2b_exp;
  logic [3:0] w6_exp;

  initial begin
    checks = 0;
    errs   = 0;
    sel    = 1'b0;
    rst_n  = 1'b0;
    set_in(1'b1, 1'b0, 4'h0, 1'b1);
    set_in(1'b0, 1'b1, 4'h5, 1'b1);

    // Reset held with valid_i high
    #12;
    chk("rst_rdy",  o_rdy,  1'b0);
    chk("rst_vld",  o_vld,  1'b0);
    chk("rst_ser",  o_ser,  1'b0);
    chk("rst_last", o_last, 1'b0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 4'h0, 1'b1);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", o_rdy, 1'b1);
    chk("rel_vld", o_vld, 1'b0);
    repeat (2) @(negedge clk);
    chk("no_spurious", o_vld, 1'b0);

    send_word(1'b0, 4'h5, 4'b0101, "lsb5");
    send_word(1'b1, 4'h9, 4'b1001, "msb9");

    // Back-to-back 4'h7 then 4'h2: 1,1,1,0,0,1,0,0 (b2b_exp[i] is beat i)
    sel = 1'b0;
    b2b_exp = 8'b0010_0111;
    @(negedge clk);
    set_in(1'b0, 1'b1, 4'h7, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_vld%0d", i), o_vld, 1'b1);
      chk($sformatf("b2b_bit%0d", i), o_ser, b2b_exp[i]);
      chk($sformatf("b2b_last%0d", i), o_last, (i == 3) || (i == 7));
      chk($sformatf("b2b_rdy%0d", i), o_rdy, (i == 3) || (i == 7));
      if (i == 0) set_in(1'b0, 1'b1, 4'h2, 1'b1);
      if (i == 4) set_in(1'b0, 1'b0, 4'h0, 1'b1);
    end
    @(negedge clk);
    chk("b2b_done_vld", o_vld, 1'b0);

    // Backpressure on 4'h6 (0,1,1,0) with data_i changed mid-word
    @(negedge clk);
    set_in(1'b0, 1'b1, 4'h6, 1'b1);
    @(negedge clk);
    chk("bp_bit0", o_ser, 1'b0);
    set_in(1'b0, 1'b0, 4'hF, 1'b1);
    @(negedge clk);
    chk("bp_bit1", o_ser, 1'b1);
    set_in(1'b0, 1'b0, 4'h9, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_vld%0d", i), o_vld, 1'b1);
      chk($sformatf("bp_hold_bit%0d", i), o_ser, 1'b1);
      chk($sformatf("bp_hold_last%0d", i), o_last, 1'b0);
      chk($sformatf("bp_hold_rdy%0d", i), o_rdy, 1'b0);
    end
    set_in(1'b0, 1'b0, 4'h0, 1'b1);
    @(negedge clk);
    chk("bp_bit2", o_ser, 1'b1);
    chk("bp_last2", o_last, 1'b0);
    @(negedge clk);
    chk("bp_bit3", o_ser, 1'b0);
    chk("bp_last3", o_last, 1'b1);
    @(negedge clk);
    chk("bp_done_vld", o_vld, 1'b0);

    // Reset mid-word after bit 2 of 4'h3 (1,1,0,0)
    w6_exp = 4'b0011;
    @(negedge clk);
    set_in(1'b0, 1'b1, 4'h3, 1'b1);
    @(negedge clk);
    chk("mr_bit0", o_ser, w6_exp[0]);
    set_in(1'b0, 1'b0, 4'h0, 1'b1);
    @(negedge clk);
    chk("mr_bit1", o_ser, w6_exp[1]);
    rst_n = 1'b0;
    #1;
    chk("mr_vld",  o_vld,  1'b0);
    chk("mr_ser",  o_ser,  1'b0);
    chk("mr_last", o_last, 1'b0);
    chk("mr_rdy",  o_rdy,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_rel_rdy", o_rdy, 1'b1);
    @(negedge clk);
    chk("mr_rel_vld", o_vld, 1'b0);
    send_word(1'b0, 4'h4, 4'b0100, "post4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
